// File: rtl/fix_msg_reader.sv
// fix_msg_reader: captures message boundaries {start, end} into a small
// descriptor queue, then walks each message through the CAM read port and
// presents the words on a valid/ready stream with sop/eop flags.
// Each word costs READ -> LATCH -> SEND, so at least three cycles per word.
// DESC_DEPTH must be a power of two, at least 2.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a descriptor; pops the queue head when present
// READ   | rd_en_o pulsed for cur_addr
// LATCH  | CAM data returns; captured with sop/eop at cycle end
// SEND   | word presented; held stable until msg_ready_i
module fix_msg_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DESC_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic                  store_start_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    input  logic                  store_end_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] msg_data_o,
    output logic                  msg_valid_o,
    output logic                  msg_sop_o,
    output logic                  msg_eop_o,
    input  logic                  msg_ready_i,
    output logic                  desc_full_o,
    output logic                  desc_overflow_o,
    output logic                  proto_err_o,
    output logic                  busy_o
);

    localparam int PTR_W  = $clog2(DESC_DEPTH);
    localparam int CNT_W  = $clog2(DESC_DEPTH + 1);
    localparam int DESC_W = 2 * ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_LATCH = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Pending start and sticky error flags
    logic                  pend_valid_q;
    logic [ADDR_WIDTH-1:0] pend_start_q;
    logic                  overflow_q;
    logic                  proto_err_q;

    // Descriptor queue
    logic [DESC_W-1:0]     desc_mem [DESC_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  desc_empty;
    logic                  desc_full;
    logic                  push_req;
    logic                  push_ok;
    logic                  push_drop;
    logic                  pop;
    logic [DESC_W-1:0]     head;
    logic [ADDR_WIDTH-1:0] head_start;
    logic [ADDR_WIDTH-1:0] head_end;

    // Message walk datapath
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;

    assign desc_empty = (count_q == '0);
    assign desc_full  = (count_q == CNT_W'(DESC_DEPTH));

    // A push uses the pend_start held before this cycle, so an end arriving
    // together with a new start closes the old message first.
    assign push_req  = store_end_i && pend_valid_q;
    assign push_ok   = push_req && (!desc_full || pop);
    assign push_drop = push_req && desc_full && !pop;

    assign head       = desc_mem[rd_ptr_q];
    assign head_start = head[DESC_W-1:ADDR_WIDTH];
    assign head_end   = head[ADDR_WIDTH-1:0];

    assign msg_data_o      = data_q;
    assign msg_sop_o       = sop_q;
    assign msg_eop_o       = eop_q;
    assign desc_full_o     = desc_full;
    assign desc_overflow_o = overflow_q;
    assign proto_err_o     = proto_err_q;

    // Pending-start capture and sticky error flags, independent of the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_start_q <= '0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            if (store_start_i) begin
                pend_start_q <= start_addr_i;
                pend_valid_q <= 1'b1;
            end else if (store_end_i) begin
                pend_valid_q <= 1'b0;
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
            if (store_end_i && !pend_valid_q) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Descriptor queue pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Descriptor storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            desc_mem[wr_ptr_q] <= {pend_start_q, end_addr_i};
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!desc_empty) begin
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: state_d = S_SEND;
            S_SEND: begin
                if (msg_ready_i) begin
                    state_d = eop_q ? S_IDLE : S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; rd_addr_o is forced to zero outside READ
    always_comb begin
        rd_en_o     = 1'b0;
        rd_addr_o   = '0;
        msg_valid_o = 1'b0;
        pop         = 1'b0;
        busy_o      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  pop = !desc_empty;
            S_READ: begin
                rd_en_o   = 1'b1;
                rd_addr_o = cur_addr_q;
            end
            S_SEND:  msg_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: descriptor load, word capture, address advance
    always_comb begin
        cur_addr_d  = cur_addr_q;
        last_addr_d = last_addr_q;
        first_d     = first_q;
        data_d      = data_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        case (state_q)
            S_IDLE: begin
                if (!desc_empty) begin
                    cur_addr_d  = head_start;
                    last_addr_d = head_end;
                    first_d     = 1'b1;
                end
            end
            S_LATCH: begin
                data_d = rd_data_i;
                sop_d  = first_q;
                eop_d  = (cur_addr_q == last_addr_q);
            end
            S_SEND: begin
                // Address wraps naturally modulo 2^ADDR_WIDTH
                if (msg_ready_i && !eop_q) begin
                    cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                    first_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr_q  <= '0;
            last_addr_q <= '0;
            first_q     <= 1'b0;
            data_q      <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            last_addr_q <= last_addr_d;
            first_q     <= first_d;
            data_q      <= data_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
        end
    end

endmodule

// File: tb/tb_fix_msg_reader.sv
// Scoreboard bench for fix_msg_reader: stimulus pushes expected words,
// a negedge monitor checks reads, handshakes and hold stability.
module tb_fix_msg_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DD = 4;
    localparam int NA = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] start_addr_i;
    logic          store_start_i;
    logic [AW-1:0] end_addr_i;
    logic          store_end_i;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_i;
    logic [DW-1:0] msg_data_o;
    logic          msg_valid_o;
    logic          msg_sop_o;
    logic          msg_eop_o;
    logic          msg_ready_i;
    logic          desc_full_o;
    logic          desc_overflow_o;
    logic          proto_err_o;
    logic          busy_o;

    fix_msg_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DESC_DEPTH(DD)) dut (
        .clk(clk), .rst(rst),
        .start_addr_i(start_addr_i), .store_start_i(store_start_i),
        .end_addr_i(end_addr_i), .store_end_i(store_end_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .msg_data_o(msg_data_o), .msg_valid_o(msg_valid_o),
        .msg_sop_o(msg_sop_o), .msg_eop_o(msg_eop_o), .msg_ready_i(msg_ready_i),
        .desc_full_o(desc_full_o), .desc_overflow_o(desc_overflow_o),
        .proto_err_o(proto_err_o), .busy_o(busy_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] cam [NA];
    int            n_checks = 0;
    int            n_err = 0;
    int            outstanding = 0;
    int            room = 1000000;
    bit            pend_v = 0;
    logic [AW-1:0] pend_s = '0;
    bit            exp_ovf = 0;
    bit            exp_perr = 0;
    bit            read_pending = 0;
    bit            hold_v = 0;
    logic [DW-1:0] held_d;
    logic [1:0]    held_f;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a message is the run of addresses start, start+1, ...
    // modulo the CAM size, ending at end inclusive.
    function automatic void model_push(logic [AW-1:0] s, logic [AW-1:0] e);
        int    d;
        word_t w;
        if (room == 0) begin
            exp_ovf = 1;
            return;
        end
        room--;
        outstanding++;
        d = int'(e) - int'(s);
        if (d < 0) d += NA;
        for (int i = 0; i <= d; i++) begin
            w.addr = AW'((int'(s) + i) % NA);
            w.data = cam[w.addr];
            w.sop  = (i == 0);
            w.eop  = (i == d);
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        outstanding  = 0;
        pend_v       = 0;
        exp_ovf      = 0;
        exp_perr     = 0;
        read_pending = 0;
        hold_v       = 0;
    endfunction

    // One clock of store strobes; entered and left at posedge+1
    task automatic drive(bit st, logic [AW-1:0] a, bit en, logic [AW-1:0] e);
        store_start_i = st;
        start_addr_i  = a;
        store_end_i   = en;
        end_addr_i    = e;
        if (en) begin
            if (pend_v) begin
                model_push(pend_s, e);
                pend_v = 0;
            end else begin
                exp_perr = 1;
            end
        end
        if (st) begin
            pend_v = 1;
            pend_s = a;
        end
        @(posedge clk); #1;
        store_start_i = 0;
        store_end_i   = 0;
    endtask

    task automatic drain(bit rand_rdy);
        int k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < 5000) begin
            msg_ready_i = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk); #1;
            k++;
        end
        check("drain_words_left", exp_q.size(), 0);
    endtask

    task automatic wait_valid(string name);
        int k = 0;
        while (!msg_valid_o && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, msg_valid_o, 1);
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // CAM model: data valid one cycle after the read strobe, garbage otherwise
    initial begin
        logic          en;
        logic [AW-1:0] a;
        rd_data_i = '0;
        forever begin
            @(negedge clk);
            en = rd_en_o;
            a  = rd_addr_o;
            @(posedge clk); #1;
            rd_data_i = en ? cam[a] : DW'($urandom);
        end
    end

    // Monitor: read address order, single read per word, hold, handshakes
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (rd_en_o) begin
                if (read_pending) check("extra_read", 1, 0);
                else if (exp_q.size() == 0) check("unexpected_read", 1, 0);
                else check("rd_addr", rd_addr_o, exp_q[0].addr);
                read_pending = 1;
            end
            if (hold_v) begin
                check("hold_valid", msg_valid_o, 1);
                check("hold_data", msg_data_o, held_d);
                check("hold_flags", {msg_sop_o, msg_eop_o}, held_f);
            end
            if (msg_valid_o && msg_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("word_data", msg_data_o, w.data);
                    check("word_sop_eop", {msg_sop_o, msg_eop_o}, {w.sop, w.eop});
                    if (w.eop) outstanding--;
                end
                read_pending = 0;
                hold_v = 0;
            end else if (msg_valid_o) begin
                hold_v = 1;
                held_d = msg_data_o;
                held_f = {msg_sop_o, msg_eop_o};
            end else begin
                hold_v = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        int n;
        bit seen;
        rst = 1;
        store_start_i = 0; store_end_i = 0;
        start_addr_i = '0; end_addr_i = '0;
        msg_ready_i = 0;
        for (int i = 0; i < NA; i++) cam[i] = DW'($urandom);
        #1;
        check("rst_ctrl", {rd_en_o, msg_valid_o, msg_sop_o, msg_eop_o, desc_full_o,
                           desc_overflow_o, proto_err_o, busy_o}, 0);
        check("rst_data_addr", {msg_data_o, rd_addr_o}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // 3..5 with ready high: latency and 9-cycle word train
        msg_ready_i = 1;
        drive(1, 5'd3, 0, 5'd0);
        drive(0, 5'd0, 1, 5'd5);
        t = 0;
        while (!rd_en_o && t < 20) begin @(negedge clk); t++; end
        check("first_read_latency", t, 2);
        n = 0;
        while (!(msg_valid_o && msg_ready_i && msg_eop_o) && n < 40) begin
            @(negedge clk); n++;
        end
        check("read_to_last_hs", n, 8);
        @(posedge clk); #1;
        drain(0);

        // wrap-around 30..1
        drive(1, 5'd30, 0, 5'd0);
        drive(0, 5'd0, 1, 5'd1);
        drain(1);

        // single word held under back-pressure
        msg_ready_i = 0;
        drive(1, 5'd7, 0, 5'd0);
        drive(0, 5'd0, 1, 5'd7);
        wait_valid("single_valid");
        repeat (4) @(posedge clk);
        #1;
        check("single_sop_eop", {msg_sop_o, msg_eop_o}, 2'b11);
        drain(0);

        // end with no start, then simultaneous start/end
        drive(0, 5'd0, 1, 5'd5);
        check("proto_err", proto_err_o, exp_perr);
        seen = 0;
        repeat (5) begin @(posedge clk); #1; seen |= busy_o; end
        check("proto_no_msg", seen, 0);
        drive(1, 5'd2, 0, 5'd0);
        drive(1, 5'd10, 1, 5'd12);
        drain(1);
        drive(0, 5'd0, 1, 5'd14);
        drain(1);

        // overflow: stall a message in SEND, then push 5 descriptors
        do_reset();
        msg_ready_i = 0;
        drive(1, 5'd0, 0, 5'd0);
        drive(0, 5'd0, 1, 5'd0);
        wait_valid("stall_valid");
        room = DD;
        for (int i = 0; i < 5; i++) begin
            logic [AW-1:0] s;
            s = AW'($urandom);
            drive(1, s, 0, 5'd0);
            drive(0, 5'd0, 1, s + AW'($urandom_range(0, 3)));
            check("full_after_push", desc_full_o, (i >= DD - 1));
            check("ovf_after_push", desc_overflow_o, exp_ovf);
        end
        room = 1000000;
        drain(1);
        check("full_cleared", desc_full_o, 0);
        check("ovf_sticky", desc_overflow_o, 1);

        // randomized traffic, outstanding messages bounded by queue depth
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int act;
            msg_ready_i = ($urandom_range(0, 3) != 0);
            act = $urandom_range(0, 9);
            if (act >= 3 && act <= 7 && pend_v && outstanding >= DD) act = 9;
            case (act)
                0, 1, 2: drive(1, AW'($urandom), 0, 5'd0);
                3, 4, 5: drive(0, 5'd0, 1, AW'($urandom));
                6, 7:    drive(1, AW'($urandom), 1, AW'($urandom));
                default: drive(0, 5'd0, 0, 5'd0);
            endcase
        end
        drain(1);
        check("rand_proto_err", proto_err_o, exp_perr);
        check("rand_overflow", desc_overflow_o, exp_ovf);

        // reset during SEND of word 2 of 4
        msg_ready_i = 0;
        drive(1, 5'd20, 0, 5'd0);
        drive(0, 5'd0, 1, 5'd23);
        wait_valid("w1_valid");
        msg_ready_i = 1;
        @(posedge clk); #1;
        msg_ready_i = 0;
        wait_valid("w2_valid");
        rst = 1;
        model_reset();
        #1;
        check("midrst_ctrl", {rd_en_o, msg_valid_o, msg_sop_o, msg_eop_o, desc_full_o,
                              desc_overflow_o, proto_err_o, busy_o}, 0);
        check("midrst_data_addr", {msg_data_o, rd_addr_o}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        msg_ready_i = 1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; seen |= busy_o | msg_valid_o | rd_en_o; end
        check("post_rst_idle", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
